// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state
// encoding, parity-mode constants and the bit-vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit value decided by two-of-three agreement between mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks and a
// sample counter (0..OVERSAMPLE-1) advanced by each tick. Both restart
// on request so sampling lines up with a detected start edge.
module uart_baud_tick #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          restart,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_cnt
);

  localparam int DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: CLOCK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
  end

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Divider and sample counter; restart takes priority over a pending tick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt    <= '0;
      sample_cnt <= '0;
    end else if (restart) begin
      div_cnt    <= '0;
      sample_cnt <= '0;
    end else if (tick) begin
      div_cnt    <= '0;
      sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: synchronised, majority-voted sampling,
// optional parity, 1 or 2 stop bits, break handling and a single-entry
// valid/ready output register that drops frames (with overrun) when full.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even, 8..16");
  end

  logic rx_meta, rx_sync;
  logic [1:0] sync_fill;
  logic armed;

  uart_state_e state, state_next;
  logic restart, tick;
  logic [SW-1:0] sample_cnt;
  logic samp_lo, samp_mid;
  logic vote, vote_now, bit_end;

  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic par_acc, par_acc_next;
  logic par_err_q, par_err_next;
  logic frame_acc, frame_acc_next;
  logic stop_cnt, stop_cnt_next;
  logic done, done_ferr;

  uart_baud_tick #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk        (clk),
    .rstn       (rstn),
    .restart    (restart),
    .tick       (tick),
    .sample_cnt (sample_cnt)
  );

  // Two-flop synchroniser; the line is only trusted for a start edge once
  // real samples have filled the chain and shown an idle (high) level.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      else if (rx_sync)      armed     <= 1'b1;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
    end else if (tick) begin
      if (sample_cnt == S_LO)  samp_lo  <= rx_sync;
      if (sample_cnt == S_MID) samp_mid <= rx_sync;
    end
  end

  assign vote     = majority3(samp_lo, samp_mid, rx_sync);
  assign vote_now = tick && (sample_cnt == S_HI);
  assign bit_end  = tick && (sample_cnt == S_LAST);
  assign busy     = (state != ST_IDLE);

  // Receive FSM state and per-frame datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_acc   <= 1'b0;
      par_err_q <= 1'b0;
      frame_acc <= 1'b0;
      stop_cnt  <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      par_acc   <= par_acc_next;
      par_err_q <= par_err_next;
      frame_acc <= frame_acc_next;
      stop_cnt  <= stop_cnt_next;
    end
  end

  // Next-state and datapath updates; the frame completes at the last stop vote.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next     = state;
    restart        = 1'b0;
    shreg_next     = shreg;
    bit_cnt_next   = bit_cnt;
    par_acc_next   = par_acc;
    par_err_next   = par_err_q;
    frame_acc_next = frame_acc;
    stop_cnt_next  = stop_cnt;
    done           = 1'b0;
    done_ferr      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (armed && !rx_sync) begin
          state_next     = ST_START;
          restart        = 1'b1;
          bit_cnt_next   = '0;
          par_acc_next   = 1'b0;
          par_err_next   = 1'b0;
          frame_acc_next = 1'b0;
          stop_cnt_next  = 1'b0;
        end
      end

      ST_START: begin
        if (vote_now && vote) state_next = ST_IDLE;
        else if (bit_end)     state_next = ST_DATA;
      end

      ST_DATA: begin
        if (vote_now) begin
          shreg_next   = {vote, shreg[DATA_BITS-1:1]};
          par_acc_next = par_acc ^ vote;
        end
        if (bit_end) begin
          if (bit_cnt == B_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (vote_now)
          par_err_next = (PARITY == PAR_ODD) ? ~(par_acc ^ vote) : (par_acc ^ vote);
        if (bit_end) state_next = ST_STOP;
      end

      ST_STOP: begin
        if (vote_now) begin
          if (stop_cnt == STOP_LAST) begin
            done       = 1'b1;
            done_ferr  = frame_acc | ~vote;
            state_next = (done_ferr && !rx_sync) ? ST_BREAK_WAIT : ST_IDLE;
          end else begin
            frame_acc_next = frame_acc | ~vote;
          end
        end
        if (bit_end) stop_cnt_next = 1'b1;
      end

      ST_BREAK_WAIT: begin
        if (rx_sync) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Single-entry output register: load when empty or being drained,
  // otherwise drop the new frame and flag overrun for one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_frame_err  <= 1'b0;
      m_parity_err <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done && (!m_valid || m_ready)) begin
        m_valid      <= 1'b1;
        m_data       <= shreg;
        m_frame_err  <= done_ferr;
        m_parity_err <= (PARITY != PAR_NONE) && par_err_q;
      end else begin
        if (m_valid && m_ready) m_valid <= 1'b0;
        if (done)               overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1..2.
REQ-006 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit, even, legal 8..16.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port m_data, output, DATA_BITS, received word, LSB first on line.
REQ-011 SHALL have port m_valid, output, 1, m_data and flags valid.
REQ-012 SHALL have port m_ready, input, 1, consumer accepts word when m_valid and m_ready are both high.
REQ-013 SHALL have port m_frame_err, output, 1, framing error flag qualified by m_valid.
REQ-014 SHALL have port m_parity_err, output, 1, parity error flag qualified by m_valid; 0 when PARITY=0.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-018 SHALL generate a one-cycle tick every DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE) clocks; DIV < 1 is an elaboration error.
REQ-019 SHALL restart the tick divider and sample counter on the IDLE->START transition so that sampling is aligned to the start edge.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP, and BREAK_WAIT.
REQ-021 SHALL, in each bit, take a 2-of-3 majority vote of samples at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2, and OVERSAMPLE/2+1 as the bit value.
REQ-022 SHALL go IDLE->START when the synchronized rx is 0.
REQ-023 SHALL go START->IDLE with no output if the start bit votes 1 (false start); otherwise it SHALL go to DATA.
REQ-024 SHALL shift DATA_BITS bits LSB first, then go to PARITY if PARITY!=0, else to STOP.
REQ-025 SHALL set the parity error when the XOR of the data bits and the parity bit is not 1 (odd) or not 0 (even).
REQ-026 SHALL set the framing error if any stop bit votes 0.
REQ-027 SHALL complete the frame at the vote of the last stop bit, not at the end of that bit, so back-to-back frames resynchronize.
REQ-028 SHALL, on completion without framing error, return to IDLE.
REQ-029 SHALL, on completion with framing error while rx=0, go to BREAK_WAIT, and SHALL leave BREAK_WAIT to IDLE only after synchronized rx=1.
REQ-030 SHALL load m_data and the flags and assert m_valid 1 clk after the completing vote, provided the output register is empty or is being accepted in that same cycle.
REQ-031 SHALL hold m_valid, m_data, and the flags stable until m_valid && m_ready is true.
REQ-032 SHALL, if a frame completes while m_valid=1 and m_ready=0, drop the new frame, keep the held word unchanged, and pulse overrun for 1 clk.
REQ-033 SHALL treat simultaneous accept and completion as a load, with no overrun.
REQ-034 SHALL keep the receive FSM independent of m_ready; backpressure never stalls reception.

Reset
REQ-035 SHALL, when rstn=0 at a clk edge, set state to IDLE, clear all counters, set synchronizer flops to 1, and clear m_data, m_valid, m_frame_err, m_parity_err, overrun, and busy to 0.
REQ-036 SHALL, on reset mid-frame, discard the partial frame; after rstn rises, a frame SHALL be recognized only after a new falling edge.

Structure
REQ-037 SHALL take the state enum and parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) from shared package uart_pkg, for reuse by the transmitter.
REQ-038 SHALL place the divider and sample counter in sub-module uart_baud_tick (parameters CLOCK_FREQ, BAUD, OVERSAMPLE; ports clk, rstn, restart, tick).

Verification
REQ-039 SHALL check a basic frame: CLOCK_FREQ=1_600_000, BAUD=10_000 (160 clk/bit), defaults, send 0xA5 -> m_valid with m_data=0xA5, both error flags 0, valid asserted 1 clk after the stop vote.
REQ-040 SHALL check parity: PARITY=2, DATA_BITS=7, send 0x55 with parity bit 0 -> parity_err=0; send with parity bit 1 -> m_parity_err=1, m_data=0x55.
REQ-041 SHALL check glitch rejection: a 40-clk low pulse on an idle line -> no m_valid, busy returns to 0; a single-sample glitch inside a data bit -> correct byte from the majority vote.
REQ-042 SHALL check backpressure: hold m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11 and overrun pulses once; raise m_ready -> accepts 0x11, no 0x22.
REQ-043 SHALL check break: hold rx low for 20 bit times -> exactly one word 0x00 with m_frame_err=1, no further words until rx high, then 0x3C is received correctly.
REQ-044 SHALL check reset: assert rstn=0 mid-DATA of a frame -> all outputs 0 next clk, no word from the partial frame; a subsequent 0x81 is received correctly.
